inst_axi_rd_bridge: RTL and testbench

Responder for the CPU's instruction-side SRAM-like port (req / addr_ok / data_ok). It converts each accepted fetch request into a single-beat AXI4 read, then returns the data with a one-cycle data_ok pulse. The block sits between the fetch stage and the AXI interconnect, and supports one outstanding transaction.

---
 rtl/inst_axi_rd_bridge_if.sv | 58 +++++
 rtl/inst_axi_rd_bridge.sv | 94 +++++++++
 tb/tb_inst_axi_rd_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for the instruction fetch bridge.
//   inst_sram_if : CPU fetch-side SRAM-like port (req / addr_ok / data_ok).
//                  master = fetch stage, slave = bridge.
//   axi_rd_if    : AXI4 read address + read data channels.
//                  master = bridge, slave = interconnect.

interface inst_sram_if;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_rerr;

  modport master (
    output inst_req, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata, inst_rerr
  );

  modport slave (
    input  inst_req, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata, inst_rerr
  );
endinterface

interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: turns each accepted SRAM-like fetch request into a
// single-beat AXI4 read and returns the data with a one-cycle data_ok pulse.
// One transaction outstanding at a time.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a fetch; addr_ok high, request latched on inst_req
// AR     | address phase; arvalid high until arready
// R      | data phase; rready high until rvalid, beat captured
// DONE   | data_ok (and rerr) pulse for one cycle, then back to IDLE

module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic      clk,
  input  logic      resetn,
  inst_sram_if.slave inst,
  axi_rd_if.master   axi
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic [31:0] rdata_r;
  logic        err_r;

  // rid and rlast carry no information for single-beat, single-outstanding reads.
  logic unused_axi;
  assign unused_axi = &{1'b0, axi.rid, axi.rlast};

  // Next-state decode; handshakes only advance the FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (inst.inst_req) state_nxt = S_AR;
      S_AR:    if (axi.arready)   state_nxt = S_R;
      S_R:     if (axi.rvalid)    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Request latch; held through AR so the address phase ignores inst_addr changes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_r <= 32'd0;
      size_r <= 2'd0;
    end else if (state == S_IDLE && inst.inst_req) begin
      addr_r <= inst.inst_addr;
      size_r <= inst.inst_size;
    end
  end

  // Read beat capture; only the R-state beat is taken, early rvalid is ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else if (state == S_R && axi.rvalid) begin
      rdata_r <= axi.rdata;
      err_r   <= (axi.rresp != 2'b00);
    end
  end

  // Outputs are pure state decodes or constants; no input-to-output path.
  assign inst.inst_addr_ok = (state == S_IDLE);
  assign inst.inst_data_ok = (state == S_DONE);
  assign inst.inst_rerr    = (state == S_DONE) & err_r;
  assign inst.inst_rdata   = rdata_r;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = addr_r;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_r};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state == S_AR);
  assign axi.rready  = (state == S_R);

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge. Inputs are driven and outputs sampled
// 1 time unit after each rising edge; "cycle N" counts from the addr_ok handshake.

module tb_inst_axi_rd_bridge;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  inst_sram_if inst ();
  axi_rd_if    axi ();

  inst_axi_rd_bridge #(.ARID_VAL(4'd0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst),
    .axi    (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    inst.inst_req  = 1'b0;
    inst.inst_size = 2'd2;
    inst.inst_addr = 32'd0;
    axi.arready = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = 32'd0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b1;
    axi.rvalid  = 1'b0;
    repeat (3) tick();

    // Reset state
    resetn = 1'b1;
    chk("rst_addr_ok", 32'(inst.inst_addr_ok), 32'd1);
    chk("rst_data_ok", 32'(inst.inst_data_ok), 32'd0);
    chk("rst_rerr",    32'(inst.inst_rerr),    32'd0);
    chk("rst_arvalid", 32'(axi.arvalid),       32'd0);
    chk("rst_rready",  32'(axi.rready),        32'd0);
    chk("rst_rdata",   inst.inst_rdata,        32'd0);
    chk("arid",        32'(axi.arid),          32'd0);
    chk("arlen",       32'(axi.arlen),         32'd0);
    chk("arburst",     32'(axi.arburst),       32'd1);

    // Single fetch, zero-wait slaves
    inst.inst_req = 1'b1; inst.inst_addr = 32'hbfc00000; inst.inst_size = 2'd2;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'h3c1a8000; axi.rresp = 2'b00;
    chk("t1_c0_addr_ok", 32'(inst.inst_addr_ok), 32'd1);
    tick();
    inst.inst_req = 1'b0;
    chk("t1_c1_arvalid", 32'(axi.arvalid), 32'd1);
    chk("t1_c1_araddr",  axi.araddr, 32'hbfc00000);
    chk("t1_c1_arsize",  32'(axi.arsize), 32'd2);
    chk("t1_c1_rready",  32'(axi.rready), 32'd0);
    tick();
    chk("t1_c2_rready",  32'(axi.rready), 32'd1);
    chk("t1_c2_arvalid", 32'(axi.arvalid), 32'd0);
    tick();
    chk("t1_c3_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t1_c3_rdata",   inst.inst_rdata, 32'h3c1a8000);
    chk("t1_c3_rerr",    32'(inst.inst_rerr), 32'd0);
    chk("t1_c3_addr_ok", 32'(inst.inst_addr_ok), 32'd0);
    tick();
    chk("t1_c4_addr_ok", 32'(inst.inst_addr_ok), 32'd1);
    chk("t1_c4_data_ok", 32'(inst.inst_data_ok), 32'd0);

    // AR backpressure: arready low for cycles 1..5
    inst.inst_req = 1'b1; inst.inst_addr = 32'h80001000; inst.inst_size = 2'd2;
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h12345678;
    tick();
    inst.inst_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      inst.inst_addr = (c % 2 == 1) ? 32'h5555aaaa : 32'haaaa5555;
      #1;
      chk("t2_arvalid_hold", 32'(axi.arvalid), 32'd1);
      chk("t2_araddr_hold",  axi.araddr, 32'h80001000);
      chk("t2_rready_off",   32'(axi.rready), 32'd0);
      tick();
    end
    axi.arready = 1'b1;
    chk("t2_c6_arvalid", 32'(axi.arvalid), 32'd1);
    tick();
    chk("t2_c7_rready",  32'(axi.rready), 32'd1);
    chk("t2_c7_data_ok", 32'(inst.inst_data_ok), 32'd0);
    tick();
    chk("t2_c8_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t2_c8_rdata",   inst.inst_rdata, 32'h12345678);
    tick();

    // Early rvalid during AR, then R stall of 3 cycles
    inst.inst_req = 1'b1; inst.inst_addr = 32'h80002000;
    axi.arready = 1'b0; axi.rvalid = 1'b0;
    tick();
    inst.inst_req = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 32'h11111111;
    chk("t3_c1_rready", 32'(axi.rready), 32'd0);
    tick();
    axi.arready = 1'b1;
    chk("t3_c2_rready", 32'(axi.rready), 32'd0);
    chk("t3_c2_rdata_kept", inst.inst_rdata, 32'h12345678);
    tick();
    axi.rvalid = 1'b0; axi.rdata = 32'h22222222;
    for (int c = 3; c <= 5; c++) begin
      chk("t3_stall_rready",  32'(axi.rready), 32'd1);
      chk("t3_stall_data_ok", 32'(inst.inst_data_ok), 32'd0);
      chk("t3_stall_rdata",   inst.inst_rdata, 32'h12345678);
      tick();
    end
    axi.rvalid = 1'b1; axi.rdata = 32'h600dc0de;
    chk("t3_c6_rready", 32'(axi.rready), 32'd1);
    tick();
    chk("t3_c7_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t3_c7_rdata",   inst.inst_rdata, 32'h600dc0de);
    tick();
    chk("t3_c8_data_ok", 32'(inst.inst_data_ok), 32'd0);
    chk("t3_c8_rdata",   inst.inst_rdata, 32'h600dc0de);

    // Error response, with inst_size = 3 passed straight through
    inst.inst_req = 1'b1; inst.inst_addr = 32'h80003003; inst.inst_size = 2'd3;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'hdeadbeef; axi.rresp = 2'b10;
    tick();
    inst.inst_req = 1'b0;
    chk("t4_c1_arsize", 32'(axi.arsize), 32'd3);
    chk("t4_c1_araddr", axi.araddr, 32'h80003003);
    tick();
    tick();
    chk("t4_c3_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t4_c3_rerr",    32'(inst.inst_rerr), 32'd1);
    chk("t4_c3_rdata",   inst.inst_rdata, 32'hdeadbeef);
    tick();
    axi.rresp = 2'b00;
    chk("t4_c4_rerr", 32'(inst.inst_rerr), 32'd0);

    // Back-to-back with req held high
    inst.inst_req = 1'b1; inst.inst_addr = 32'hbfc00000; inst.inst_size = 2'd2;
    axi.rdata = 32'h00000001;
    chk("t5_c0_addr_ok", 32'(inst.inst_addr_ok), 32'd1);
    tick();
    inst.inst_addr = 32'hbfc00004;
    chk("t5_c1_addr_ok", 32'(inst.inst_addr_ok), 32'd0);
    chk("t5_c1_araddr",  axi.araddr, 32'hbfc00000);
    tick();
    chk("t5_c2_addr_ok", 32'(inst.inst_addr_ok), 32'd0);
    tick();
    axi.rdata = 32'h00000002;
    chk("t5_c3_addr_ok", 32'(inst.inst_addr_ok), 32'd0);
    chk("t5_c3_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t5_c3_rdata",   inst.inst_rdata, 32'h00000001);
    tick();
    chk("t5_c4_addr_ok", 32'(inst.inst_addr_ok), 32'd1);
    tick();
    inst.inst_req = 1'b0;
    chk("t5_c5_araddr",  axi.araddr, 32'hbfc00004);
    chk("t5_c5_arvalid", 32'(axi.arvalid), 32'd1);
    tick();
    chk("t5_c6_data_ok", 32'(inst.inst_data_ok), 32'd0);
    tick();
    chk("t5_c7_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t5_c7_rdata",   inst.inst_rdata, 32'h00000002);
    tick();

    // Reset while in R
    inst.inst_req = 1'b1; inst.inst_addr = 32'h80004000;
    axi.arready = 1'b1; axi.rvalid = 1'b0;
    tick();
    inst.inst_req = 1'b0;
    tick();
    chk("t6_c2_rready", 32'(axi.rready), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("t6_rst_rready",  32'(axi.rready), 32'd0);
    chk("t6_rst_data_ok", 32'(inst.inst_data_ok), 32'd0);
    chk("t6_rst_addr_ok", 32'(inst.inst_addr_ok), 32'd1);
    chk("t6_rst_rdata",   inst.inst_rdata, 32'd0);

    // Fresh fetch after the mid-transaction reset
    inst.inst_req = 1'b1; inst.inst_addr = 32'h00000100;
    axi.rvalid = 1'b1; axi.rdata = 32'ha5a5a5a5;
    tick();
    inst.inst_req = 1'b0;
    chk("t6_c1_araddr", axi.araddr, 32'h00000100);
    tick();
    tick();
    chk("t6_c3_data_ok", 32'(inst.inst_data_ok), 32'd1);
    chk("t6_c3_rdata",   inst.inst_rdata, 32'ha5a5a5a5);
    tick();
    chk("t6_c4_addr_ok", 32'(inst.inst_addr_ok), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
